iob_cache_fe_arbiter: RTL and testbench

- Round-robin arbiter that shares one iob_cache front-end IOb native slave port between N_REQ masters, e.g. CPU instruction and data ports.
- Forwards one request at a time to the cache.
- Tracks the single outstanding read and routes the cache's rvalid/rdata back to the requester that issued it.
- Sits between the masters and the iob_cache_axi or iob_cache_iob top-level front-end port.

---
 rtl/iob_cache_fe_arbiter_pkg.sv | 11 +
 rtl/iob_cache_rr_grant.sv | 32 +++
 rtl/iob_cache_fe_arbiter.sv | 142 ++++++++++++++
 tb/tb_iob_cache_fe_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_cache_fe_arbiter_pkg.sv
// Shared types and constants for the iob_cache front-end arbiter.
package iob_cache_fe_arbiter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_RD = 1'b1
  } arb_state_t;

  localparam int STATS_CNT_W = 16;

endpackage

// File: rtl/iob_cache_rr_grant.sv
// Combinational round-robin priority rotator: picks the first valid index
// at or after ptr (mod N). Reusable by any shared-port arbiter.
module iob_cache_rr_grant #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt,
  output logic         any_valid
);

  localparam int WP = W + 1;

  logic [N-1:0]  rot;
  logic [WP-1:0] off;
  logic [WP-1:0] sum;

  always_comb begin
    // Rotate so that bit 0 is the requester currently holding priority.
    rot = N'({valid, valid} >> ptr);
    off = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) off = WP'(j);
    end
    sum = {1'b0, ptr} + off;
    gnt = (sum >= WP'(N)) ? W'(sum - WP'(N)) : W'(sum);
  end

  assign any_valid = |valid;

endmodule

// File: rtl/iob_cache_fe_arbiter.sv
// Round-robin arbiter sharing one iob_cache front-end port among N_REQ masters.
// Define IOB_CACHE_FE_ARB_STATS_EN to add per-requester grant counters.
module iob_cache_fe_arbiter
  import iob_cache_fe_arbiter_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int N_REQ_W = $clog2(N_REQ)
) (
  input  logic                       clk_i,
  input  logic                       cke_i,
  input  logic                       rst_i,
  input  logic [N_REQ-1:0]           req_valid_i,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr_i,
  input  logic [N_REQ*DATA_W-1:0]    req_wdata_i,
  input  logic [N_REQ*DATA_W/8-1:0]  req_wstrb_i,
  output logic [N_REQ-1:0]           req_ready_o,
  output logic [N_REQ-1:0]           req_rvalid_o,
  output logic [DATA_W-1:0]          req_rdata_o,
  output logic                       cache_valid_o,
  output logic [ADDR_W-1:0]          cache_addr_o,
  output logic [DATA_W-1:0]          cache_wdata_o,
  output logic [DATA_W/8-1:0]        cache_wstrb_o,
  input  logic                       cache_ready_i,
  input  logic                       cache_rvalid_i,
  input  logic [DATA_W-1:0]          cache_rdata_i
`ifdef IOB_CACHE_FE_ARB_STATS_EN
  ,
  input  logic                       stats_clr_i,
  output logic [N_REQ*STATS_CNT_W-1:0] grant_cnt_o
`endif
);

  localparam int STRB_W = DATA_W / 8;

  // Handshake: a request transfers on a cycle where cache_valid_o and
  // cache_ready_i are both high; the requester must hold its fields until
  // its req_ready_o bit is seen. Read data is valid only with req_rvalid_o.

  arb_state_t          state, state_nxt;
  logic [N_REQ_W-1:0]  rr_ptr, owner, gnt, ptr_nxt;
  logic                any_valid, accept;
  logic [ADDR_W-1:0]   gnt_addr;
  logic [DATA_W-1:0]   gnt_wdata;
  logic [STRB_W-1:0]   gnt_wstrb;

  iob_cache_rr_grant #(
    .N (N_REQ),
    .W (N_REQ_W)
  ) u_rr_grant (
    .valid     (req_valid_i),
    .ptr       (rr_ptr),
    .gnt       (gnt),
    .any_valid (any_valid)
  );

  always_comb begin
    gnt_addr  = '0;
    gnt_wdata = '0;
    gnt_wstrb = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt == N_REQ_W'(k)) begin
        gnt_addr  = req_addr_i[k*ADDR_W +: ADDR_W];
        gnt_wdata = req_wdata_i[k*DATA_W +: DATA_W];
        gnt_wstrb = req_wstrb_i[k*STRB_W +: STRB_W];
      end
    end
  end

  assign ptr_nxt = (gnt == N_REQ_W'(N_REQ - 1)) ? '0 : gnt + 1'b1;

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    cache_valid_o = 1'b0;
    cache_addr_o  = '0;
    cache_wdata_o = '0;
    cache_wstrb_o = '0;
    req_ready_o   = '0;
    req_rvalid_o  = '0;
    req_rdata_o   = '0;
    if (!rst_i) begin
      req_rdata_o = cache_rdata_i;
      case (state)
        IDLE: begin
          cache_valid_o = any_valid;
          cache_addr_o  = gnt_addr;
          cache_wdata_o = gnt_wdata;
          cache_wstrb_o = gnt_wstrb;
          if (any_valid) req_ready_o[gnt] = cache_ready_i;
          accept = any_valid & cache_ready_i;
          // Writes stay in IDLE so they can stream back to back.
          if (accept && gnt_wstrb == '0) state_nxt = WAIT_RD;
        end
        WAIT_RD: begin
          req_rvalid_o[owner] = cache_rvalid_i;
          if (cache_rvalid_i) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else if (cke_i) begin
      state <= state_nxt;
      if (accept) begin
        rr_ptr <= ptr_nxt;
        owner  <= gnt;
      end
    end
  end

`ifdef IOB_CACHE_FE_ARB_STATS_EN
  logic [STATS_CNT_W-1:0] grant_cnt [N_REQ];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_REQ; k++) grant_cnt[k] <= '0;
    end else if (cke_i) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (stats_clr_i) begin
          grant_cnt[k] <= '0;
        end else if (accept && gnt == N_REQ_W'(k) && grant_cnt[k] != '1) begin
          grant_cnt[k] <= grant_cnt[k] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_cnt_o = '0;
    for (int k = 0; k < N_REQ; k++) grant_cnt_o[k*STATS_CNT_W +: STATS_CNT_W] = grant_cnt[k];
  end
`endif

endmodule

// File: tb/tb_iob_cache_fe_arbiter.sv
// Scoreboard bench for iob_cache_fe_arbiter: directed scenarios followed by
// randomized traffic checked against a queue-based reference model.
module tb_iob_cache_fe_arbiter;

  localparam int N_REQ  = 3;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = 16;
  localparam int TXN_W  = 8 + ADDR_W + DATA_W + STRB_W;
  localparam int RD_W   = 8 + DATA_W;
  localparam int CYC_W  = 1 + 2 * N_REQ;

  // ---------------- clock / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      cke_i, rst_i;
  logic [N_REQ-1:0]          req_valid_i;
  logic [N_REQ*ADDR_W-1:0]   req_addr_i;
  logic [N_REQ*DATA_W-1:0]   req_wdata_i;
  logic [N_REQ*STRB_W-1:0]   req_wstrb_i;
  logic [N_REQ-1:0]          req_ready_o, req_rvalid_o;
  logic [DATA_W-1:0]         req_rdata_o;
  logic                      cache_valid_o;
  logic [ADDR_W-1:0]         cache_addr_o;
  logic [DATA_W-1:0]         cache_wdata_o;
  logic [STRB_W-1:0]         cache_wstrb_o;
  logic                      cache_ready_i, cache_rvalid_i;
  logic [DATA_W-1:0]         cache_rdata_i;
`ifdef IOB_CACHE_FE_ARB_STATS_EN
  logic                      stats_clr_i;
  logic [N_REQ*CNT_W-1:0]    grant_cnt_o;
`endif

  iob_cache_fe_arbiter #(
    .N_REQ  (N_REQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk_i          (clk),
    .cke_i          (cke_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .req_wstrb_i    (req_wstrb_i),
    .req_ready_o    (req_ready_o),
    .req_rvalid_o   (req_rvalid_o),
    .req_rdata_o    (req_rdata_o),
    .cache_valid_o  (cache_valid_o),
    .cache_addr_o   (cache_addr_o),
    .cache_wdata_o  (cache_wdata_o),
    .cache_wstrb_o  (cache_wstrb_o),
    .cache_ready_i  (cache_ready_i),
    .cache_rvalid_i (cache_rvalid_i),
    .cache_rdata_i  (cache_rdata_i)
`ifdef IOB_CACHE_FE_ARB_STATS_EN
    ,
    .stats_clr_i    (stats_clr_i),
    .grant_cnt_o    (grant_cnt_o)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [CYC_W-1:0] cyc_q[$];
  logic [TXN_W-1:0] txn_q[$];
  logic [RD_W-1:0]  rd_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Stimulus: each master's pending request, plus cache-side controls.
  bit              m_valid [N_REQ];
  logic [ADDR_W-1:0] m_addr  [N_REQ];
  logic [DATA_W-1:0] m_wdata [N_REQ];
  logic [STRB_W-1:0] m_wstrb [N_REQ];
  bit              c_rst, c_cke, c_ready, c_rvalid, c_clr;
  logic [DATA_W-1:0] c_rdata;

  // Reference model: priority pointer, one outstanding read, grant counts.
  int ptr = 0;
  int owner = 0;
  bit busy = 1'b0;
  int cnt [N_REQ];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int k, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
    m_valid[k] = 1'b1;
    m_addr[k]  = a;
    m_wdata[k] = d;
    m_wstrb[k] = s;
  endtask

  task automatic clear_reqs();
    for (int k = 0; k < N_REQ; k++) m_valid[k] = 1'b0;
  endtask

  function automatic logic [STRB_W-1:0] rand_strb();
    if ($urandom_range(0, 1) == 0) return '0;
    return STRB_W'($urandom_range(1, (1 << STRB_W) - 1));
  endfunction

  task automatic apply();
    for (int k = 0; k < N_REQ; k++) begin
      req_valid_i[k]                   = m_valid[k];
      req_addr_i[k*ADDR_W +: ADDR_W]   = m_addr[k];
      req_wdata_i[k*DATA_W +: DATA_W]  = m_wdata[k];
      req_wstrb_i[k*STRB_W +: STRB_W]  = m_wstrb[k];
    end
    rst_i          = c_rst;
    cke_i          = c_cke;
    cache_ready_i  = c_ready;
    cache_rvalid_i = c_rvalid;
    cache_rdata_i  = c_rdata;
`ifdef IOB_CACHE_FE_ARB_STATS_EN
    stats_clr_i    = c_clr;
`endif
  endtask

  // Drive one cycle, predict its outputs, advance the model over the edge.
  task automatic tick();
    int g;
    bit acc, cv, anyv;
    logic [N_REQ-1:0] er, ev;
    apply();
    g = 0; acc = 0; cv = 0; er = '0; ev = '0; anyv = 0;
    for (int k = 0; k < N_REQ; k++) anyv |= m_valid[k];
    if (!c_rst) begin
      if (!busy) begin
        if (anyv) begin
          cv = 1;
          for (int i = N_REQ - 1; i >= 0; i--)
            if (m_valid[(ptr + i) % N_REQ]) g = (ptr + i) % N_REQ;
          if (c_ready) begin
            acc = 1;
            er  = N_REQ'(1) << g;
            txn_q.push_back({8'(g), m_addr[g], m_wdata[g], m_wstrb[g]});
          end
        end
      end else if (c_rvalid) begin
        ev = N_REQ'(1) << owner;
        rd_q.push_back({8'(owner), c_rdata});
      end
    end
    cyc_q.push_back({cv, er, ev});
    if (c_rst) begin
      ptr = 0; owner = 0; busy = 0;
      for (int k = 0; k < N_REQ; k++) cnt[k] = 0;
    end else if (c_cke) begin
      if (acc) begin
        ptr   = (g + 1) % N_REQ;
        owner = g;
        busy  = (m_wstrb[g] == '0);
      end else if (busy && c_rvalid) begin
        busy = 0;
      end
      for (int k = 0; k < N_REQ; k++) begin
        if (c_clr) cnt[k] = 0;
        else if (acc && g == k && cnt[k] < 65535) cnt[k]++;
      end
    end
    @(posedge clk);
    #1;
    if (acc) m_valid[g] = 1'b0;
  endtask

`ifdef IOB_CACHE_FE_ARB_STATS_EN
  task automatic check_stats(input string name);
    for (int k = 0; k < N_REQ; k++)
      check(name, grant_cnt_o[k*CNT_W +: CNT_W], CNT_W'(cnt[k]));
  endtask
`endif

  // ---------------- monitor ----------------
  logic [CYC_W-1:0] mon_c;
  logic [TXN_W-1:0] mon_t;
  logic [RD_W-1:0]  mon_r;
  logic [N_REQ-1:0] mon_oh;

  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      mon_c = cyc_q.pop_front();
      check("cache_valid", cache_valid_o, mon_c[CYC_W-1]);
      check("req_ready", req_ready_o & req_valid_i, mon_c[2*N_REQ-1:N_REQ]);
      check("req_rvalid", req_rvalid_o, mon_c[N_REQ-1:0]);
      if (rst_i) check("rst_fields", {cache_addr_o, cache_wdata_o, cache_wstrb_o}, '0);
      if (cache_valid_o && cache_ready_i) begin
        if (txn_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL txn_unexpected: got accept ready=%b want none at %0t", req_ready_o, $time);
        end else begin
          mon_t  = txn_q.pop_front();
          mon_oh = N_REQ'(1) << mon_t[TXN_W-1 -: 8];
          check("txn_owner", req_ready_o, mon_oh);
          check("txn_fields", {cache_addr_o, cache_wdata_o, cache_wstrb_o},
                mon_t[ADDR_W+DATA_W+STRB_W-1:0]);
        end
      end
      if (|req_rvalid_o) begin
        if (rd_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rd_unexpected: got rvalid=%b want none at %0t", req_rvalid_o, $time);
        end else begin
          mon_r  = rd_q.pop_front();
          mon_oh = N_REQ'(1) << mon_r[RD_W-1 -: 8];
          check("rd_owner", req_rvalid_o, mon_oh);
          check("rd_data", req_rdata_o, mon_r[DATA_W-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int k = 0; k < N_REQ; k++) begin
      m_valid[k] = 0; m_addr[k] = '0; m_wdata[k] = '0; m_wstrb[k] = '0; cnt[k] = 0;
    end
    c_rst = 1; c_cke = 1; c_ready = 1; c_rvalid = 0; c_clr = 0; c_rdata = '0;
    apply();
    @(posedge clk);
    #1;
    repeat (3) tick();
    c_rst = 0;

    // Single read from master 1, response three cycles after accept.
    set_req(1, 30'h10, '0, '0);
    tick();
    tick();
    tick();
    c_rvalid = 1; c_rdata = 32'hDEADBEEF;
    tick();
    c_rvalid = 0;
    tick();

    // Masters 0 and 1 stream writes; grants must alternate.
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 2; k++)
        if (!m_valid[k]) set_req(k, ADDR_W'($urandom), $urandom, STRB_W'($urandom_range(1, 15)));
      tick();
    end
    clear_reqs();
    tick();

    // Master 0 reads while master 1 waits; master 1 goes first afterwards.
    set_req(0, 30'h20, '0, '0);
    tick();
    set_req(1, 30'h24, 32'h1111_2222, 4'hF);
    tick();
    tick();
    c_rvalid = 1; c_rdata = 32'hCAFE_F00D;
    tick();
    c_rvalid = 0;
    set_req(0, 30'h28, 32'h3333_4444, 4'h3);
    tick();
    tick();

    // Cache stalls five cycles under a master 1 request.
    clear_reqs();
    set_req(1, 30'h30, 32'h5555_6666, 4'h1);
    c_ready = 0;
    repeat (5) tick();
    c_ready = 1;
    tick();
    tick();

    // Reset during an outstanding read; the late response is dropped.
    set_req(0, 30'h40, '0, '0);
    tick();
    c_rst = 1;
    tick();
    c_rst = 0; c_rvalid = 1; c_rdata = 32'hBAD0_BAD0;
    tick();
    c_rvalid = 0;
    set_req(0, 30'h44, 32'h7, 4'h8);
    set_req(2, 30'h48, 32'h9, 4'h4);
    tick();
    tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      c_rst    = ($urandom_range(0, 199) == 0);
      c_cke    = ($urandom_range(0, 9) != 0);
      c_ready  = ($urandom_range(0, 3) != 0);
      c_rvalid = busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      c_rdata  = $urandom;
      c_clr    = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < N_REQ; k++) begin
        if (!m_valid[k]) begin
          if ($urandom_range(0, 2) == 0) set_req(k, ADDR_W'($urandom), $urandom, rand_strb());
        end else if ($urandom_range(0, 31) == 0) begin
          m_valid[k] = 0;
        end
      end
      tick();
    end

    // Drain any outstanding read.
    clear_reqs();
    c_rst = 0; c_cke = 1; c_clr = 0; c_ready = 1;
    repeat (4) begin
      c_rvalid = busy;
      tick();
    end
    c_rvalid = 0;
    tick();

`ifdef IOB_CACHE_FE_ARB_STATS_EN
    check_stats("stats_random");
    c_rst = 1;
    tick();
    c_rst = 0;
    repeat (3) begin
      set_req(0, ADDR_W'($urandom), $urandom, 4'hF);
      tick();
    end
    set_req(1, ADDR_W'($urandom), $urandom, 4'hF);
    tick();
    check("stats_directed", grant_cnt_o, {16'd0, 16'd1, 16'd3});
    check_stats("stats_model");
    c_clr = 1;
    tick();
    c_clr = 0;
    check("stats_clear", grant_cnt_o, '0);
`endif

    check("txn_q_empty", txn_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
